sd_cmd: RTL
===========

Name: sd_cmd

Overview:
- SD bus command-line engine, directly downstream of the SD bus controller FSM.
- Takes a command index and argument and serialises a 48-bit command frame with CRC7 onto the CMD line.
- Receives the card response (none, 48-bit or 136-bit), checks it, and returns the packed response fields the FSM decodes.
- Runs in the SD bus clock domain and moves one CMD bit per iclk cycle.

Parameters:
- NCR_MAX, 64: maximum cycles from command end bit to response start bit before timeout.
- NCC, 8: idle cycles inserted after a response (or after the command, if no response) before odone.

Ports:
- iclk, in, 1: SD bus clock.
- irst, in, 1: reset, asynchronous, active-low.
- istart, in, 1: one-cycle request to send a command; sampled only in IDLE.
- iindex, in, 6: command index.
- iarg, in, 32: command argument.
- icmd, in, 1: CMD line input from pad.
- ocmd, out, 1: CMD line output value.
- ocmd_oe, out, 1: CMD output enable.
- odone, out, 1: one-cycle pulse when the transaction is complete.
- oresp, out, 76: packed response.
- ocrc_err, out, 1: response CRC or end-bit error, valid with odone.
- otimeout, out, 1: no response start bit seen, valid with odone.
- obusy, out, 1: high whenever state is not IDLE.

Behaviour:
- Reset (irst low):
  - state IDLE; ocmd=1, ocmd_oe=0, odone=0, oresp=0, ocrc_err=0, otimeout=0, obusy=0; CRC register cleared.
- Response type is decoded from the latched index:
  - 2, 9: R2, 136 bits.
  - 41: R3, 48 bits, CRC not checked.
  - 15: no response.
  - All others: 48 bits with CRC7 check.
- IDLE:
  - On istart, latch iindex/iarg, clear ocrc_err and otimeout, go to TX.
  - istart in any other state is ignored.
- TX:
  - Lasts 48 cycles starting the cycle after istart; ocmd_oe=1 throughout.
  - Bit order: 0, 1, index[5:0], arg[31:0], CRC7[6:0], 1, MSB first.
  - CRC7 (polynomial x^7+x^3+1, init 0) covers the first 40 bits.
  - After the end bit, ocmd_oe=0 and ocmd=1. Go to WAIT, or to GAP if there is no response.
- WAIT:
  - Count cycles while icmd is high.
  - icmd=0 enters RX; that bit is the start bit.
  - If the count reaches NCR_MAX, set otimeout=1, leave oresp unchanged, and go to GAP.
- RX:
  - Shift in the remaining 47 bits (48-bit response) or 135 bits (R2).
  - 48-bit checks: CRC7 over bits [47:8] must match bits [7:1]; bit 0 must be 1; otherwise ocrc_err=1.
  - R2 checks: CRC7 over bits [127:8] must match bits [7:1]; bit 0 must be 1.
  - R3 checks: end bit only.
  - On completion, load oresp regardless of the error flag.
    - 48-bit response: oresp[31:0] = frame[39:8], oresp[75:32] = 0.
    - R2: oresp = frame[83:8], i.e. CSD/CID bits [83:8].
- GAP:
  - NCC cycles with ocmd_oe=0.
  - Then pulse odone for one cycle and return to IDLE.
  - A new istart is accepted on the cycle after odone.
- Latency without response: odone occurs 48+NCC+1 cycles after istart.
- R1b busy on DAT0 is not handled here; the data block owns it.
- Reset mid-transaction:
  - Immediately release the CMD line (oe=0) and return to IDLE.
  - No odone is produced.

Decomposition:
- Shared package sd_pkg holds:
  - Response-type encoding (RESP_NONE, RESP_48, RESP_48_NOCRC, RESP_136).
  - The index-to-type decode function.
  - Constants for the frame lengths (48, 136).
- Sub-module sd_crc7: serial CRC7 with clear, enable and data bit, and a 7-bit output. Two instances, TX and RX, or one shared instance, since TX and RX never overlap.

Test Plan:
- CMD55 with arg 0x00000000 → ocmd stream equals frame 0x770000000065; card model returns R1 0x37_00000120_xx with valid CRC → odone, oresp[31:0]=0x00000120, ocrc_err=0.
- ACMD41 with arg 0x80300000 → card returns R3 with CRC field 0x7F and payload 0x80FF8000 → oresp[31:0]=0x80FF8000, ocrc_err=0.
- CMD9 → card returns 136-bit CSD with READ_BL_LEN=9, C_SIZE=0xFFF, C_SIZE_MULT=7 → oresp[75:72]=9, oresp[65:54]=0xFFF, oresp[41:39]=7.
- CMD13 with no card response → otimeout=1 and odone exactly NCR_MAX+NCC+1 cycles after the TX end bit; oresp unchanged.
- CMD15 → odone 57 cycles after istart; CMD line never sampled.
- R1 with one CRC bit flipped → ocrc_err=1.
- Separately, irst asserted mid-RX → ocmd_oe=0 at once, no odone; the next istart works normally.

Source files
------------

// File: rtl/sd_pkg.sv
// sd_pkg: shared definitions for the SD command-line engine.
//   - resp_t       : response type the engine expects after a command
//   - state_t      : command engine FSM states
//   - CMD_LEN etc. : frame lengths on the CMD line
//   - decode_resp  : command index -> response type
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_48,
    RESP_48_NOCRC,
    RESP_136
  } resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_t;

  // Command and 48-bit response frame length
  localparam int CMD_LEN      = 48;
  // R2 (CID/CSD) response frame length
  localparam int R2_LEN       = 136;
  // Leading bits of a 48-bit frame that are covered by CRC7
  localparam int CMD_BODY_LEN = 40;

  // R2 for CMD2/CMD9, R3 (no CRC) for ACMD41, nothing for CMD15,
  // everything else is a CRC-protected 48-bit response.
  function automatic resp_t decode_resp(input logic [5:0] index);
    resp_t rt;
    case (index)
      6'd2, 6'd9: rt = RESP_136;
      6'd41:      rt = RESP_48_NOCRC;
      6'd15:      rt = RESP_NONE;
      default:    rt = RESP_48;
    endcase
    return rt;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: bit-serial CRC7 (x^7 + x^3 + 1, init 0) as used on the SD CMD line.
// Ports:
//   iclk  - SD bus clock
//   irst  - asynchronous active-low reset, clears the CRC
//   clr   - synchronous clear, wins over en
//   en    - fold din into the CRC this cycle
//   din   - serial data bit, MSB of the frame first
//   crc   - current CRC7 value
module sd_crc7 (
  input  logic       iclk,
  input  logic       irst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;

  assign fb = din ^ crc[6];

  // Feedback taps at bit 0 and bit 3 implement x^7 + x^3 + 1
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_cmd.sv
// sd_cmd: SD bus CMD-line engine. Serialises a 48-bit command frame with CRC7,
// waits for and receives the card response (none, 48-bit or 136-bit), checks
// it and returns the packed response fields. One CMD bit per iclk cycle.
// Ports:
//   iclk, irst         - SD bus clock, asynchronous active-low reset
//   istart             - one-cycle command request, only honoured in IDLE
//   iindex, iarg       - command index and argument
//   icmd               - CMD line input from the pad
//   ocmd, ocmd_oe      - CMD line output value and output enable
//   odone              - one-cycle pulse at the end of the transaction
//   oresp              - packed response (R2: frame[83:8], else frame[39:8])
//   ocrc_err           - response CRC/end-bit error, valid with odone
//   otimeout           - no response start bit seen, valid with odone
//   obusy              - engine is not idle
module sd_cmd
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC     = 8
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        istart,
  input  logic [5:0]  iindex,
  input  logic [31:0] iarg,
  input  logic        icmd,
  output logic        ocmd,
  output logic        ocmd_oe,
  output logic        odone,
  output logic [75:0] oresp,
  output logic        ocrc_err,
  output logic        otimeout,
  output logic        obusy
);

  localparam int WAIT_W = $clog2(NCR_MAX + 1);
  localparam int GAP_W  = $clog2(NCC + 1);

  state_t            state, state_d;
  resp_t             resp_type;
  logic [39:0]       tx_sr;
  logic [7:0]        bit_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [82:0]       rx_sr;
  logic [83:0]       rx_full;
  logic [7:0]        rx_last;
  logic [2:0]        crc_idx;
  logic              rx_err;

  logic              crc_clr;
  logic              crc_en;
  logic              crc_bit;
  logic [6:0]        crc_val;

  sd_crc7 u_crc (
    .iclk (iclk),
    .irst (irst),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (crc_bit),
    .crc  (crc_val)
  );

  // Only the low 84 bits of any response are ever used, so older bits of an
  // R2 frame simply fall off the top of the shift register.
  assign rx_full = {rx_sr, icmd};
  assign rx_last = (resp_type == RESP_136) ? 8'(R2_LEN - 1) : 8'(CMD_LEN - 1);
  // TX bit_cnt 40..46 selects CRC bits 6..0
  assign crc_idx = 3'd6 - bit_cnt[2:0];
  // Both frame sizes carry CRC7 in [7:1] and the end bit in [0]
  assign rx_err  = !icmd || ((resp_type != RESP_48_NOCRC) && (crc_val != rx_full[7:1]));
  assign obusy   = (state != ST_IDLE);

  // FSM state register
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, CMD line drive and CRC control
  always_comb begin
    state_d = state;
    ocmd    = 1'b1;
    ocmd_oe = 1'b0;
    odone   = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_bit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (istart) begin
          state_d = ST_TX;
          crc_clr = 1'b1;
        end
      end
      ST_TX: begin
        ocmd_oe = 1'b1;
        if (bit_cnt < 8'(CMD_BODY_LEN)) begin
          ocmd    = tx_sr[39];
          crc_en  = 1'b1;
          crc_bit = tx_sr[39];
        end else if (bit_cnt < 8'(CMD_LEN - 1)) begin
          ocmd = crc_val[crc_idx];
        end
        if (bit_cnt == 8'(CMD_LEN - 1)) begin
          state_d = (resp_type == RESP_NONE) ? ST_GAP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Start bit is zero, so clearing the CRC already accounts for it
        if (!icmd) begin
          state_d = ST_RX;
          crc_clr = 1'b1;
        end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
          state_d = ST_GAP;
        end
      end
      ST_RX: begin
        crc_bit = icmd;
        // R2 CRC skips the start, transmission and reserved header byte
        if (resp_type == RESP_136) begin
          crc_en = (bit_cnt >= 8'd8) && (bit_cnt < 8'(R2_LEN - 8));
        end else begin
          crc_en = (bit_cnt < 8'(CMD_BODY_LEN));
        end
        if (bit_cnt == rx_last) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // NCC idle cycles, then one extra cycle carrying odone
        if (gap_cnt == GAP_W'(NCC)) begin
          odone   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath: frame shift registers, counters and result flags
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      resp_type <= RESP_NONE;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      gap_cnt   <= '0;
      rx_sr     <= '0;
      oresp     <= '0;
      ocrc_err  <= 1'b0;
      otimeout  <= 1'b0;
    end else begin
      wait_cnt <= (state == ST_WAIT && icmd) ? wait_cnt + 1'b1 : '0;
      gap_cnt  <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
      case (state)
        ST_IDLE: begin
          if (istart) begin
            resp_type <= decode_resp(iindex);
            tx_sr     <= {2'b01, iindex, iarg};
            bit_cnt   <= '0;
            ocrc_err  <= 1'b0;
            otimeout  <= 1'b0;
          end
        end
        ST_TX: begin
          tx_sr   <= {tx_sr[38:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
        end
        ST_WAIT: begin
          if (!icmd) begin
            rx_sr   <= '0;
            bit_cnt <= 8'd1;
          end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
            otimeout <= 1'b1;
          end
        end
        ST_RX: begin
          rx_sr   <= rx_full[82:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == rx_last) begin
            ocrc_err <= rx_err;
            if (resp_type == RESP_136) begin
              oresp <= rx_full[83:8];
            end else begin
              oresp <= {44'b0, rx_full[39:8]};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
